hit_resolver: RTL and testbench
===============================

# hit_resolver

Per-frame combat resolver that consumes both players' attack windows and positions and produces the hit-side results: one-shot hit detection, per-player hitstun, health and round KO. It sits between `player_attack`/`player_move` and `player_state_anim`, driving the `hitstun_active` inputs that are currently tied low. Geometry matches the debug hitbox/hurtbox overlay exactly, so what is drawn is what hits.

## Interface
Parameters:
- MAX_HEALTH, 100 — health loaded at reset/new round (7-bit)
- HIT_DAMAGE, 10 — health removed per clean hit
- HITSTUN_FRAMES, 12 — defender stun length in SCEN frames
- GUARD_DAMAGE, 2 — damage for a guarded hit (HIT_GUARD_EN only)
- GUARD_STUN_FRAMES, 4 — stun for a guarded hit (HIT_GUARD_EN only)
- HITBOX_W / HITBOX_H, 40 / 80 — attack box size
- HURTBOX_W / HURTBOX_H, 40 / 45 — body box size

Ports:
- clk  in  1  pixel clock (25 MHz)
- reset_n  in  1  asynchronous, active-low reset
- SCEN  in  1  one-cycle frame tick
- new_round  in  1  restart request, honoured only in KO
- p1_pos_x, p1_pos_y, p2_pos_x, p2_pos_y  in  10 each  sprite origin
- p1_facing, p2_facing  in  1  1 = facing right
- p1_attack_damage, p2_attack_damage  in  1  active hit window
- p1_guard, p2_guard  in  1  guard held (ignored unless HIT_GUARD_EN)
- p1_hitstun_active, p2_hitstun_active  out  1  stun counter nonzero
- p1_health, p2_health  out  7  current health
- p1_hit, p2_hit  out  1  one-clk pulse: this player was just hit
- ko  out  1  round over
- winner  out  2  00 none, 01 P1, 10 P2, 11 double KO

## Operation
- Boxes are computed in 12-bit with a +64 bias, so no wrap at the screen edge. Intervals are half-open.
  - Hitbox x0 = facing ? pos_x+85 : pos_x−5; width HITBOX_W.
  - Hitbox y0 = pos_y−5; height HITBOX_H.
  - Hurtbox x0 = pos_x+40, y0 = pos_y+53; size HURTBOX_W×HURTBOX_H.
- Overlap on an axis = a0 < b1 && b0 < a1; a hit needs overlap on both axes.
- One hit per attack: a per-attacker `connected` flag sets on a hit and clears on the first SCEN where that attacker's attack_damage = 0.
- Hit on P(n) requires all of: state FIGHT; opponent attack_damage = 1; opponent `connected` = 0; box overlap; p(n)_hitstun_active = 0.
  - A hit on a defender already in stun is ignored, and the attacker's `connected` stays 0.
- Clean hit: health −= HIT_DAMAGE, saturating at 0; stun counter loads HITSTUN_FRAMES.
- Simultaneous hits on both players (trade) are both applied in the same frame.
- Stun counter decrements by 1 per SCEN while nonzero.
- FSM:
  - FIGHT → KO on the frame any health reaches 0; winner is set then (11 if both reach 0).
  - KO: all hits ignored; stun counters keep decrementing.
  - KO + new_round: both healths → MAX_HEALTH, stun counters and `connected` flags cleared, winner → 00, → FIGHT.
  - new_round in FIGHT is ignored.

## Timing
- All evaluation happens on the clk edge where SCEN = 1. Outputs are registered and visible the next cycle.
- p(n)_hit is high exactly one clk, in the cycle after the resolving SCEN.
- Health, ko and winner update in the same cycle as hit.
- hitstun_active rises with hit and stays high for exactly HITSTUN_FRAMES SCEN periods.
- Inputs are sampled only on SCEN cycles; changes between ticks have no effect.
- reset_n low, asynchronously and including mid-stun or in KO: health = MAX_HEALTH, hitstun = 0, hit = 0, ko = 0, winner = 00, FSM = FIGHT, `connected` flags = 0.

## Configuration
- HIT_GUARD_EN defined:
  - A hit lands as guarded when p(n)_guard = 1 and the defender faces the attacker: p(n)_facing == (opp_pos_x > p(n)_pos_x).
  - A guarded hit applies GUARD_DAMAGE and GUARD_STUN_FRAMES; p(n)_hit still pulses.
- HIT_GUARD_EN undefined: guard inputs are ignored and every hit is clean.

## Test plan
- Clean hit, one only:
  - Stimulus: P1 (200,250) facing right, P2 (260,250); P1 attack_damage held 7 frames.
  - Expected: exactly one p2_hit pulse; p2_health 100→90; p2_hitstun_active high for 12 SCENs, then 0.
- Miss: same as above but P2 x=300 (hurtbox starts at 340, hitbox ends at 325) → no hit, health stays 100.
- Trade: P1 (200,250) facing right, P2 (260,250) facing left, both attack the same frame → both healths 90, both stunned.
- KO:
  - Stimulus: 10 spaced clean hits P1→P2.
  - Expected: p2_health = 0, ko = 1, winner = 01; an 11th attack changes nothing.
  - Then new_round pulse → healths 100, ko = 0, winner = 00.
- Hit during stun: a second P1 attack landing while p2_hitstun_active = 1 → no damage.
- Reset mid-stun: assert reset_n = 0 at stun frame 5 → outputs return to reset values immediately, without waiting for clk.
- With HIT_GUARD_EN, P2 facing left and guarding → p2_health 100→98, stun 4 frames.

Source files
------------

// File: rtl/hit_resolver.sv
// rtl/hit_resolver.sv - per-frame combat resolver: hit detection, hitstun, health, KO (optional macro: HIT_GUARD_EN)
module hit_resolver #(
  parameter int unsigned MAX_HEALTH        = 100,
  parameter int unsigned HIT_DAMAGE        = 10,
  parameter int unsigned HITSTUN_FRAMES    = 12,
  parameter int unsigned GUARD_DAMAGE      = 2,
  parameter int unsigned GUARD_STUN_FRAMES = 4,
  parameter int unsigned HITBOX_W          = 40,
  parameter int unsigned HITBOX_H          = 80,
  parameter int unsigned HURTBOX_W         = 40,
  parameter int unsigned HURTBOX_H         = 45
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SCEN,
  input  logic       new_round,
  input  logic [9:0] p1_pos_x,
  input  logic [9:0] p1_pos_y,
  input  logic [9:0] p2_pos_x,
  input  logic [9:0] p2_pos_y,
  input  logic       p1_facing,
  input  logic       p2_facing,
  input  logic       p1_attack_damage,
  input  logic       p2_attack_damage,
  input  logic       p1_guard,
  input  logic       p2_guard,
  output logic       p1_hitstun_active,
  output logic       p2_hitstun_active,
  output logic [6:0] p1_health,
  output logic [6:0] p2_health,
  output logic       p1_hit,
  output logic       p2_hit,
  output logic       ko,
  output logic [1:0] winner
);

  typedef enum logic {ST_FIGHT = 1'b0, ST_KO = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [6:0] health1_q, health1_d, health2_q, health2_d;
  logic [7:0] stun1_q, stun1_d, stun2_q, stun2_d;
  logic       conn1_q, conn1_d, conn2_q, conn2_d;
  logic       hit1_q, hit1_d, hit2_q, hit2_d;
  logic       ko_q, ko_d;
  logic [1:0] winner_q, winner_d;

  logic       hit_on_p1, hit_on_p2;
  logic       guard1, guard2;
  logic [6:0] dmg1, dmg2;
  logic [7:0] stun_ld1, stun_ld2;

  // Box edges live in a +64 biased 12-bit space so boxes hanging off the left edge never wrap.
  function automatic logic [11:0] biased(input logic [9:0] v);
    return {2'b00, v} + 12'd64;
  endfunction

  function automatic logic overlap(input logic [11:0] a0, input logic [11:0] a1,
                                   input logic [11:0] b0, input logic [11:0] b1);
    return (a0 < b1) && (b0 < a1);
  endfunction

  // Attacker hitbox (same geometry as the debug overlay) against defender hurtbox.
  function automatic logic box_hit(input logic [9:0] ax, input logic [9:0] ay, input logic af,
                                   input logic [9:0] dx, input logic [9:0] dy);
    logic [11:0] hx0, hy0, ux0, uy0;
    hx0 = af ? biased(ax) + 12'd85 : biased(ax) - 12'd5;
    hy0 = biased(ay) - 12'd5;
    ux0 = biased(dx) + 12'd40;
    uy0 = biased(dy) + 12'd53;
    return overlap(hx0, hx0 + 12'(HITBOX_W), ux0, ux0 + 12'(HURTBOX_W)) &&
           overlap(hy0, hy0 + 12'(HITBOX_H), uy0, uy0 + 12'(HURTBOX_H));
  endfunction

  function automatic logic [6:0] sat_sub(input logic [6:0] h, input logic [6:0] d);
    return (h > d) ? h - d : 7'd0;
  endfunction

`ifdef HIT_GUARD_EN
  // A guard only counts when the defender is turned toward the attacker.
  assign guard1 = p1_guard && (p1_facing == (p2_pos_x > p1_pos_x));
  assign guard2 = p2_guard && (p2_facing == (p1_pos_x > p2_pos_x));
`else
  logic unused_guard;
  assign unused_guard = &{1'b0, p1_guard, p2_guard};
  assign guard1 = 1'b0;
  assign guard2 = 1'b0;
`endif

  // Hit qualification and per-defender damage/stun selection.
  always_comb begin
    hit_on_p1 = (state_q == ST_FIGHT) && p2_attack_damage && !conn2_q && (stun1_q == 8'd0) &&
                box_hit(p2_pos_x, p2_pos_y, p2_facing, p1_pos_x, p1_pos_y);
    hit_on_p2 = (state_q == ST_FIGHT) && p1_attack_damage && !conn1_q && (stun2_q == 8'd0) &&
                box_hit(p1_pos_x, p1_pos_y, p1_facing, p2_pos_x, p2_pos_y);
    dmg1      = guard1 ? 7'(GUARD_DAMAGE) : 7'(HIT_DAMAGE);
    dmg2      = guard2 ? 7'(GUARD_DAMAGE) : 7'(HIT_DAMAGE);
    stun_ld1  = guard1 ? 8'(GUARD_STUN_FRAMES) : 8'(HITSTUN_FRAMES);
    stun_ld2  = guard2 ? 8'(GUARD_STUN_FRAMES) : 8'(HITSTUN_FRAMES);
  end

  // Frame update: everything advances only on SCEN; hit pulses last one clk.
  always_comb begin
    state_d   = state_q;
    health1_d = health1_q;
    health2_d = health2_q;
    stun1_d   = stun1_q;
    stun2_d   = stun2_q;
    conn1_d   = conn1_q;
    conn2_d   = conn2_q;
    hit1_d    = 1'b0;
    hit2_d    = 1'b0;
    ko_d      = ko_q;
    winner_d  = winner_q;
    if (SCEN) begin
      if (stun1_q != 8'd0) stun1_d = stun1_q - 8'd1;
      if (stun2_q != 8'd0) stun2_d = stun2_q - 8'd1;
      if (!p1_attack_damage) conn1_d = 1'b0;
      if (!p2_attack_damage) conn2_d = 1'b0;
      if (state_q == ST_FIGHT) begin
        if (hit_on_p1) begin
          health1_d = sat_sub(health1_q, dmg1);
          stun1_d   = stun_ld1;
          conn2_d   = 1'b1;
          hit1_d    = 1'b1;
        end
        if (hit_on_p2) begin
          health2_d = sat_sub(health2_q, dmg2);
          stun2_d   = stun_ld2;
          conn1_d   = 1'b1;
          hit2_d    = 1'b1;
        end
        if ((health1_d == 7'd0) || (health2_d == 7'd0)) begin
          state_d  = ST_KO;
          ko_d     = 1'b1;
          winner_d = {health1_d == 7'd0, health2_d == 7'd0};
        end
      end else if (new_round) begin
        state_d   = ST_FIGHT;
        health1_d = 7'(MAX_HEALTH);
        health2_d = 7'(MAX_HEALTH);
        stun1_d   = 8'd0;
        stun2_d   = 8'd0;
        conn1_d   = 1'b0;
        conn2_d   = 1'b0;
        ko_d      = 1'b0;
        winner_d  = 2'b00;
      end
    end
  end

  // State registers with asynchronous round reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FIGHT;
      health1_q <= 7'(MAX_HEALTH);
      health2_q <= 7'(MAX_HEALTH);
      stun1_q   <= 8'd0;
      stun2_q   <= 8'd0;
      conn1_q   <= 1'b0;
      conn2_q   <= 1'b0;
      hit1_q    <= 1'b0;
      hit2_q    <= 1'b0;
      ko_q      <= 1'b0;
      winner_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      health1_q <= health1_d;
      health2_q <= health2_d;
      stun1_q   <= stun1_d;
      stun2_q   <= stun2_d;
      conn1_q   <= conn1_d;
      conn2_q   <= conn2_d;
      hit1_q    <= hit1_d;
      hit2_q    <= hit2_d;
      ko_q      <= ko_d;
      winner_q  <= winner_d;
    end
  end

  assign p1_hitstun_active = (stun1_q != 8'd0);
  assign p2_hitstun_active = (stun2_q != 8'd0);
  assign p1_health         = health1_q;
  assign p2_health         = health2_q;
  assign p1_hit            = hit1_q;
  assign p2_hit            = hit2_q;
  assign ko                = ko_q;
  assign winner            = winner_q;

endmodule

// File: tb/tb_hit_resolver.sv
// tb/tb_hit_resolver.sv - directed and randomized check of hit_resolver against a frame-level model
module tb_hit_resolver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scen;
  logic       new_round;
  logic [9:0] p1_pos_x, p1_pos_y, p2_pos_x, p2_pos_y;
  logic       p1_facing, p2_facing;
  logic       p1_attack_damage, p2_attack_damage;
  logic       p1_guard, p2_guard;
  logic       p1_hitstun_active, p2_hitstun_active;
  logic [6:0] p1_health, p2_health;
  logic       p1_hit, p2_hit;
  logic       ko;
  logic [1:0] winner;

  hit_resolver dut (
    .clk(clk), .reset_n(reset_n), .SCEN(scen), .new_round(new_round),
    .p1_pos_x(p1_pos_x), .p1_pos_y(p1_pos_y), .p2_pos_x(p2_pos_x), .p2_pos_y(p2_pos_y),
    .p1_facing(p1_facing), .p2_facing(p2_facing),
    .p1_attack_damage(p1_attack_damage), .p2_attack_damage(p2_attack_damage),
    .p1_guard(p1_guard), .p2_guard(p2_guard),
    .p1_hitstun_active(p1_hitstun_active), .p2_hitstun_active(p2_hitstun_active),
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_hit(p1_hit), .p2_hit(p2_hit), .ko(ko), .winner(winner)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame inputs intended for the next SCEN
  int f_p1x, f_p1y, f_p2x, f_p2y;
  bit f_p1f, f_p2f, f_a1, f_a2, f_g1, f_g2, f_nr;

  // Reference model state
  int m_h1, m_h2, m_st1, m_st2, m_win;
  bit m_c1, m_c2, m_ko, e_hit1, e_hit2;

  int p2_pulses, p2_stun_frames;

  function automatic bit reaches(int ax, int ay, bit af, int dx, int dy);
    int hx0, hy0, ux0, uy0;
    hx0 = af ? ax + 85 : ax - 5;
    hy0 = ay - 5;
    ux0 = dx + 40;
    uy0 = dy + 53;
    return (hx0 < ux0 + 40) && (ux0 < hx0 + 40) && (hy0 < uy0 + 45) && (uy0 < hy0 + 80);
  endfunction

  task automatic model_reset();
    m_h1 = 100; m_h2 = 100; m_st1 = 0; m_st2 = 0;
    m_c1 = 0; m_c2 = 0; m_ko = 0; m_win = 0;
  endtask

  task automatic model_step();
    bit fight, on1, on2;
    int d1, d2, s1, s2;
    fight = !m_ko;
    on2 = fight && f_a1 && !m_c1 && (m_st2 == 0) && reaches(f_p1x, f_p1y, f_p1f, f_p2x, f_p2y);
    on1 = fight && f_a2 && !m_c2 && (m_st1 == 0) && reaches(f_p2x, f_p2y, f_p2f, f_p1x, f_p1y);
    d1 = 10; s1 = 12; d2 = 10; s2 = 12;
`ifdef HIT_GUARD_EN
    if (f_g1 && (f_p1f == (f_p2x > f_p1x))) begin d1 = 2; s1 = 4; end
    if (f_g2 && (f_p2f == (f_p1x > f_p2x))) begin d2 = 2; s2 = 4; end
`endif
    if (m_st1 > 0) m_st1--;
    if (m_st2 > 0) m_st2--;
    if (!f_a1) m_c1 = 0;
    if (!f_a2) m_c2 = 0;
    if (fight) begin
      if (on1) begin m_h1 = (m_h1 > d1) ? m_h1 - d1 : 0; m_st1 = s1; m_c2 = 1; end
      if (on2) begin m_h2 = (m_h2 > d2) ? m_h2 - d2 : 0; m_st2 = s2; m_c1 = 1; end
      if (m_h1 == 0 || m_h2 == 0) begin
        m_ko = 1;
        m_win = (m_h2 == 0 ? 1 : 0) + (m_h1 == 0 ? 2 : 0);
      end
    end else if (f_nr) begin
      model_reset();
    end
    e_hit1 = on1;
    e_hit2 = on2;
  endtask

  task automatic drive_frame();
    p1_pos_x = 10'(f_p1x); p1_pos_y = 10'(f_p1y);
    p2_pos_x = 10'(f_p2x); p2_pos_y = 10'(f_p2y);
    p1_facing = f_p1f; p2_facing = f_p2f;
    p1_attack_damage = f_a1; p2_attack_damage = f_a2;
    p1_guard = f_g1; p2_guard = f_g2; new_round = f_nr;
  endtask

  // Junk between ticks must never matter.
  task automatic drive_junk();
    p1_pos_x = 10'($urandom); p1_pos_y = 10'($urandom);
    p2_pos_x = 10'($urandom); p2_pos_y = 10'($urandom);
    {p1_facing, p2_facing, p1_attack_damage, p2_attack_damage} = 4'($urandom);
    {p1_guard, p2_guard, new_round} = 3'($urandom);
  endtask

  task automatic set_frame(input int p1x, input int p1y, input int p2x, input int p2y,
                           input bit p1f, input bit p2f, input bit a1, input bit a2);
    f_p1x = p1x; f_p1y = p1y; f_p2x = p2x; f_p2y = p2y;
    f_p1f = p1f; f_p2f = p2f; f_a1 = a1; f_a2 = a2;
    f_g1 = 0; f_g2 = 0; f_nr = 0;
  endtask

  task automatic run_frame();
    int idle;
    idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++) begin
      drive_junk();
      @(posedge clk); #1;
    end
    drive_frame();
    scen = 1'b1;
    @(posedge clk); #1;
    scen = 1'b0;
    drive_junk();
    model_step();
    chk("p1_hit", p1_hit, e_hit1);
    chk("p2_hit", p2_hit, e_hit2);
    chk("p1_health", p1_health, m_h1);
    chk("p2_health", p2_health, m_h2);
    chk("p1_stun", p1_hitstun_active, m_st1 > 0);
    chk("p2_stun", p2_hitstun_active, m_st2 > 0);
    chk("ko", ko, m_ko);
    chk("winner", winner, m_win);
    if (p2_hit) p2_pulses++;
    if (p2_hitstun_active) p2_stun_frames++;
    @(posedge clk); #1;
    chk("p1_hit_one_clk", p1_hit, 0);
    chk("p2_hit_one_clk", p2_hit, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    scen = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    p2_pulses = 0;
    p2_stun_frames = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    scen = 1'b0;
    set_frame(0, 0, 0, 0, 0, 0, 0, 0);
    drive_frame();
    #12;
    chk("rst_p1_health", p1_health, 100);
    chk("rst_p2_health", p2_health, 100);
    chk("rst_stun", {p1_hitstun_active, p2_hitstun_active}, 0);
    chk("rst_hit", {p1_hit, p2_hit}, 0);
    chk("rst_ko", ko, 0);
    chk("rst_winner", winner, 0);
    do_reset();

    // Clean hit, attack held 7 frames: one pulse, 12 stun frames
    set_frame(200, 250, 260, 250, 1, 0, 1, 0);
    repeat (7) run_frame();
    f_a1 = 0;
    repeat (14) run_frame();
    chk("clean_pulses", p2_pulses, 1);
    chk("clean_health", p2_health, 90);
    chk("clean_stun_len", p2_stun_frames, 12);

    // Miss: hurtbox starts beyond hitbox end
    do_reset();
    set_frame(200, 250, 300, 250, 1, 0, 1, 0);
    repeat (7) run_frame();
    chk("miss_health", p2_health, 100);
    chk("miss_pulses", p2_pulses, 0);

    // Trade
    do_reset();
    set_frame(200, 250, 260, 250, 1, 0, 1, 1);
    run_frame();
    chk("trade_h1", p1_health, 90);
    chk("trade_h2", p2_health, 90);
    chk("trade_stun", {p1_hitstun_active, p2_hitstun_active}, 3);
    f_a1 = 0; f_a2 = 0;
    repeat (13) run_frame();

    // Second attack during stun does no damage
    do_reset();
    set_frame(200, 250, 260, 250, 1, 0, 1, 0);
    run_frame();
    f_a1 = 0; run_frame();
    f_a1 = 1; run_frame();
    chk("stun_ignore_health", p2_health, 90);
    f_a1 = 0;
    repeat (12) run_frame();

    // KO after ten spaced hits, eleventh ignored, then new round
    do_reset();
    set_frame(200, 250, 260, 250, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      f_a1 = 1; run_frame();
      f_a1 = 0; repeat (12) run_frame();
    end
    chk("ko_health", p2_health, 0);
    chk("ko_flag", ko, 1);
    chk("ko_winner", winner, 1);
    f_a1 = 1; run_frame();
    f_a1 = 0; run_frame();
    chk("ko_extra_pulses", p2_pulses, 10);
    chk("ko_extra_health", p2_health, 0);
    f_nr = 1; run_frame();
    f_nr = 0;
    chk("nr_h1", p1_health, 100);
    chk("nr_h2", p2_health, 100);
    chk("nr_ko", ko, 0);
    chk("nr_winner", winner, 0);

    // Asynchronous reset mid-stun
    do_reset();
    set_frame(200, 250, 260, 250, 1, 0, 1, 0);
    run_frame();
    f_a1 = 0;
    repeat (5) run_frame();
    chk("pre_reset_stun", p2_hitstun_active, 1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_health", p2_health, 100);
    chk("async_rst_stun", p2_hitstun_active, 0);
    chk("async_rst_ko", ko, 0);
    chk("async_rst_winner", winner, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();

`ifdef HIT_GUARD_EN
    // Guarded hit while facing the attacker
    do_reset();
    set_frame(200, 250, 260, 250, 1, 0, 1, 0);
    f_g2 = 1;
    run_frame();
    f_a1 = 0;
    repeat (6) run_frame();
    chk("guard_health", p2_health, 98);
    chk("guard_stun_len", p2_stun_frames, 4);
`endif

    // Randomized frames against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      f_p1x = $urandom_range(150, 300);
      f_p2x = $urandom_range(200, 380);
      f_p1y = $urandom_range(220, 280);
      f_p2y = $urandom_range(220, 280);
      f_p1f = 1'($urandom); f_p2f = 1'($urandom);
      f_a1  = 1'($urandom); f_a2  = 1'($urandom);
      f_g1  = 1'($urandom); f_g2  = 1'($urandom);
      f_nr  = ($urandom_range(0, 9) == 0);
      run_frame();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
